// File: rtl/spw_light_link_seq.sv
// SpaceWire light link sequencer: start/backoff/retry FSM behind a 4-register Avalon-MM slave.
// Optional interrupt logic and IRQ_MASK register are built when SPW_LIGHT_LINK_SEQ_IRQ_EN is defined.
module spw_light_link_seq #(
    parameter logic [15:0] START_TIMEOUT  = 16'd1000,
    parameter logic [15:0] BACKOFF_CYCLES = 16'd100,
    parameter logic [3:0]  MAX_RETRY      = 4'd7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  in_port,
    output logic        link_start,
    output logic        link_disable,
    output logic        irq
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTING = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_BACKOFF  = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    state_t      state_r, state_next_s;
    logic [1:0]  sync1_r, sync2_r;
    logic        ctrl_r;
    logic [2:0]  event_r, event_next_s, ev_set_s, ev_clr_s;
    logic [15:0] timer_r, timer_next_s;
    logic [3:0]  retry_r, retry_next_s;
    logic [31:0] readdata_r, rd_mux_s;
    logic        link_start_r, link_disable_r;
    logic        running_s, error_s, wr_s, enable_s, link_on_s;
    logic        unused_wdata_s;

    assign running_s      = sync2_r[0];
    assign error_s        = sync2_r[1];
    assign wr_s           = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata[31:3];

    // Two-flop synchronizer for the core's link status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    // A CTRL write takes effect on the FSM in the same clock, so disabling beats a concurrent link-up.
    always_comb begin
        enable_s = ctrl_r;
        if (wr_s && (address == 2'd0)) begin
            enable_s = writedata[0];
        end else begin
            enable_s = ctrl_r;
        end
    end

    // Next-state, timer, retry and event-set logic.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = (timer_r != 16'd0) ? (timer_r - 16'd1) : 16'd0;
        retry_next_s = retry_r;
        ev_set_s     = 3'b000;
        if (!enable_s) begin
            state_next_s = ST_IDLE;
            retry_next_s = 4'd0;
            timer_next_s = 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_STARTING;
                    timer_next_s = START_TIMEOUT - 16'd1;
                end
                ST_STARTING: begin
                    if (running_s && !error_s) begin
                        state_next_s = ST_RUNNING;
                        retry_next_s = 4'd0;
                        ev_set_s[0]  = 1'b1;
                    end else if (error_s || (timer_r == 16'd0)) begin
                        state_next_s = ST_BACKOFF;
                        retry_next_s = (retry_r == 4'd15) ? 4'd15 : (retry_r + 4'd1);
                        timer_next_s = BACKOFF_CYCLES - 16'd1;
                    end else begin
                        state_next_s = ST_STARTING;
                    end
                end
                ST_RUNNING: begin
                    if (!running_s || error_s) begin
                        state_next_s = ST_BACKOFF;
                        timer_next_s = BACKOFF_CYCLES - 16'd1;
                        ev_set_s[1]  = 1'b1;
                    end else begin
                        state_next_s = ST_RUNNING;
                    end
                end
                ST_BACKOFF: begin
                    if (timer_r != 16'd0) begin
                        state_next_s = ST_BACKOFF;
                    end else if (retry_r >= MAX_RETRY) begin
                        state_next_s = ST_FAIL;
                        ev_set_s[2]  = 1'b1;
                    end else begin
                        state_next_s = ST_STARTING;
                        timer_next_s = START_TIMEOUT - 16'd1;
                    end
                end
                ST_FAIL: begin
                    state_next_s = ST_FAIL;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // EVENT update: hardware set wins over a same-clock W1C.
    always_comb begin
        ev_clr_s = 3'b000;
        if (wr_s && (address == 2'd2)) begin
            ev_clr_s = writedata[2:0];
        end else begin
            ev_clr_s = 3'b000;
        end
        event_next_s = (event_r & ~ev_clr_s) | ev_set_s;
    end

    assign link_on_s = (state_next_s == ST_STARTING) || (state_next_s == ST_RUNNING);

    // FSM, timer, retry and link output registers; link outputs track the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            timer_r        <= 16'd0;
            retry_r        <= 4'd0;
            event_r        <= 3'b000;
            link_start_r   <= 1'b0;
            link_disable_r <= 1'b1;
        end else begin
            state_r        <= state_next_s;
            timer_r        <= timer_next_s;
            retry_r        <= retry_next_s;
            event_r        <= event_next_s;
            link_start_r   <= link_on_s;
            link_disable_r <= ~link_on_s;
        end
    end

    // CTRL register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r <= 1'b0;
        end else if (wr_s && (address == 2'd0)) begin
            ctrl_r <= writedata[0];
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

`ifdef SPW_LIGHT_LINK_SEQ_IRQ_EN
    logic [2:0] mask_r;
    logic       irq_r;

    // IRQ_MASK register and level interrupt, one clock behind EVENT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= 3'b000;
            irq_r  <= 1'b0;
        end else begin
            if (wr_s && (address == 2'd3)) begin
                mask_r <= writedata[2:0];
            end else begin
                mask_r <= mask_r;
            end
            irq_r <= |(event_r & mask_r);
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    // Read address mux; unused bits read 0.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            2'd0:    rd_mux_s = {31'd0, ctrl_r};
            2'd1:    rd_mux_s = {20'd0, retry_r, 3'd0, error_s, running_s, state_r};
            2'd2:    rd_mux_s = {29'd0, event_r};
`ifdef SPW_LIGHT_LINK_SEQ_IRQ_EN
            2'd3:    rd_mux_s = {29'd0, mask_r};
`else
            2'd3:    rd_mux_s = 32'd0;
`endif
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read data register, loaded every clock regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign readdata     = readdata_r;
    assign link_start   = link_start_r;
    assign link_disable = link_disable_r;

endmodule

// File: tb/tb_spw_light_link_seq.sv
// Directed bench for spw_light_link_seq: a default-parameter instance (a) and a short-timer instance (b).
module tb_spw_light_link_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port_a, in_port_b;
    logic [31:0] readdata_a, readdata_b;
    logic        ls_a, ld_a, irq_a, ls_b, ld_b, irq_b;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    spw_light_link_seq u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a), .in_port(in_port_a),
        .link_start(ls_a), .link_disable(ld_a), .irq(irq_a)
    );

    spw_light_link_seq #(
        .START_TIMEOUT(16'd16), .BACKOFF_CYCLES(16'd8), .MAX_RETRY(4'd2)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_b), .in_port(in_port_b),
        .link_start(ls_b), .link_disable(ld_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges, so outputs must change asynchronously.
    task automatic rst();
        @(negedge clk);
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        in_port_a  = 2'b00;
        in_port_b  = 2'b00;
        #2;
        chk("rst_ls_b", ls_b, 1'b0);
        chk("rst_ld_b", ld_b, 1'b1);
        chk("rst_rd_b", readdata_b, 32'd0);
        chk("rst_irq_b", irq_b, 1'b0);
        chk("rst_ld_a", ld_a, 1'b1);
        chk("rst_rd_a", readdata_a, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Instance b, in_port held 0: STARTING 16 clocks, BACKOFF 8, twice, then FAIL.
    function automatic logic exp_dis(input int s);
        return ((s >= 17) && (s <= 24)) || (s >= 41);
    endfunction

    function automatic logic [11:0] exp_status(input int t);
        logic [3:0] r;
        logic [2:0] st;
        r  = (t >= 41) ? 4'd2 : ((t >= 17) ? 4'd1 : 4'd0);
        if (t <= 16)      st = 3'd1;
        else if (t <= 24) st = 3'd3;
        else if (t <= 40) st = 3'd1;
        else if (t <= 48) st = 3'd3;
        else              st = 3'd4;
        return {r, 5'b00000, st};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic prev_irq;
        reset_n = 1'b0;
        rst();

        // Bring-up on the default instance; in_port raised about 20 clocks after enable.
        wr(2'd0, 32'd1);
        rd(2'd0);
        chk("a_ctrl_rd", readdata_a, 32'd1);
        chk("a_ls_starting", ls_a, 1'b1);
        chk("a_ld_starting", ld_a, 1'b0);
        cyc(18);
        in_port_a = 2'b01;
        rd(2'd1);
        chk("a_status_e1", readdata_a, 32'h1);
        cyc(1);
        rd(2'd1);
        chk("a_status_e3", readdata_a, 32'h9);
        rd(2'd1);
        chk("a_status_run", readdata_a, 32'hA);
        chk("a_ls_run", ls_a, 1'b1);
        rd(2'd2);
        chk("a_event", readdata_a, 32'h1);

        // Retry exhaustion on instance b.
        rst();
        wr(2'd0, 32'd1);
        address = 2'd1;
        for (int s = 1; s <= 52; s++) begin
            if (s > 1) @(negedge clk);
            chk($sformatf("b_ldis_%0d", s), ld_b, exp_dis(s));
            chk($sformatf("b_ls_%0d", s), ls_b, !exp_dis(s));
            if (s > 1) chk($sformatf("b_status_%0d", s), readdata_b[11:0], exp_status(s - 1));
        end
        rd(2'd2);
        chk("b_fail_event", readdata_b, 32'h4);
`ifndef SPW_LIGHT_LINK_SEQ_IRQ_EN
        chk("b_irq_off", irq_b, 1'b0);
`endif

        // Error pulse while RUNNING, then recovery through STARTING.
        rst();
        in_port_b = 2'b01;
        wr(2'd0, 32'd1);
        cyc(4);
        rd(2'd1);
        chk("b_running", readdata_b, 32'hA);
        in_port_b = 2'b10;
        cyc(3);
        in_port_b = 2'b01;
        chk("b_ld_backoff", ld_b, 1'b1);
        rd(2'd2);
        chk("b_event_down", readdata_b, 32'h3);
        address = 2'd1;
        found = 1'b0;
        for (int i = 0; (i < 20) && !found; i++) begin
            @(negedge clk);
            if (readdata_b[2:0] == 3'd1) found = 1'b1;
        end
        chk("b_restart", found, 1'b1);
        rd(2'd1);
        chk("b_rerun", readdata_b, 32'hA);

        // Disable in the same clock that synchronized running is first seen (also resets mid-link).
        rst();
        wr(2'd0, 32'd1);
        cyc(2);
        in_port_b = 2'b01;
        cyc(2);
        wr(2'd0, 32'd0);
        chk("b_dis_ld", ld_b, 1'b1);
        chk("b_dis_ls", ls_b, 1'b0);
        rd(2'd1);
        chk("b_dis_idle", readdata_b, 32'h8);
        rd(2'd2);
        chk("b_dis_noevent", readdata_b, 32'h0);

        // W1C colliding with a new link_down, then plain W1C clears.
        wr(2'd0, 32'd1);
        cyc(3);
        rd(2'd2);
        chk("b_up_event", readdata_b, 32'h1);
        in_port_b = 2'b00;
        cyc(2);
        wr(2'd2, 32'h2);
        rd(2'd2);
        chk("b_w1c_collide", readdata_b, 32'h3);
        wr(2'd2, 32'h1);
        rd(2'd2);
        chk("b_w1c_bit0", readdata_b, 32'h2);
        wr(2'd2, 32'h2);
        rd(2'd2);
        chk("b_w1c_bit1", readdata_b, 32'h0);

        // Interrupt on FAIL.
        rst();
`ifdef SPW_LIGHT_LINK_SEQ_IRQ_EN
        wr(2'd3, 32'h4);
        rd(2'd3);
        chk("b_mask_rd", readdata_b, 32'h4);
        wr(2'd0, 32'd1);
        address  = 2'd2;
        found    = 1'b0;
        prev_irq = 1'b0;
        for (int i = 0; (i < 80) && !found; i++) begin
            prev_irq = irq_b;
            @(negedge clk);
            if (readdata_b[2]) found = 1'b1;
        end
        chk("b_irq_fail_seen", found, 1'b1);
        chk("b_irq_prev", prev_irq, 1'b0);
        chk("b_irq_set", irq_b, 1'b1);
        wr(2'd2, 32'h4);
        chk("b_irq_hold", irq_b, 1'b1);
        cyc(1);
        chk("b_irq_clr", irq_b, 1'b0);
`else
        wr(2'd3, 32'h7);
        rd(2'd3);
        chk("b_mask_absent", readdata_b, 32'h0);
        chk("b_irq_tied", irq_b, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
